cla_adder_pipe: RTL and testbench

//   Parametrised, 3-stage pipelined two-level carry-lookahead adder/subtractor.

---
 rtl/cla_adder_pipe_if.sv | 29 ++
 rtl/cla_adder_pipe.sv | 160 ++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_adder_pipe_if.sv
// Stream bundle for cla_adder_pipe: operand beats in, sum/carry/overflow beats out.
// A beat moves on a rising clk edge where valid and ready are both 1; a source holds
// valid and its payload stable until that edge, and ready never depends on the
// same-side valid.
interface cla_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// Three-stage two-level carry-lookahead adder/subtractor with valid/ready backpressure.
// Stage 1 forms bit and group P/G, stage 2 resolves group carries, stage 3 forms sums.
module cla_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input logic             clk,
  input logic             rst,
  cla_adder_pipe_if.slave bus
);
  localparam int NG = WIDTH / BLK;

  if ((WIDTH % BLK) != 0 || BLK < 2 || BLK > 8) begin : g_param_check
    $error("cla_adder_pipe: WIDTH must be a multiple of BLK and BLK must be 2..8");
  end

  function automatic logic [NG-1:0] group_prop(input logic [WIDTH-1:0] p);
    logic [NG-1:0] gp;
    gp = '0;
    for (int k = 0; k < NG; k++) gp[k] = &p[k*BLK +: BLK];
    return gp;
  endfunction

  // Every carry below is a flat sum of products, so no ripple chain is described.
  function automatic logic [NG-1:0] group_gen(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] g);
    logic [NG-1:0] gg;
    logic          term;
    gg = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < BLK; j++) begin
        term = g[k*BLK+j];
        for (int m = j + 1; m < BLK; m++) term = term & p[k*BLK+m];
        gg[k] = gg[k] | term;
      end
    end
    return gg;
  endfunction

  function automatic logic [NG:0] group_carry(input logic [NG-1:0] gp,
                                              input logic [NG-1:0] gg,
                                              input logic          c0);
    logic [NG:0] cg;
    logic        acc;
    logic        term;
    cg    = '0;
    cg[0] = c0;
    for (int k = 1; k <= NG; k++) begin
      acc = c0;
      for (int m = 0; m < k; m++) acc = acc & gp[m];
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) term = term & gp[m];
        acc = acc | term;
      end
      cg[k] = acc;
    end
    return cg;
  endfunction

  function automatic logic [WIDTH:0] bit_carry(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] g,
                                               input logic [NG:0]      cg);
    logic [WIDTH:0] c;
    logic           acc;
    logic           term;
    c        = '0;
    c[WIDTH] = cg[NG];
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < BLK; i++) begin
        acc = cg[k];
        for (int m = 0; m < i; m++) acc = acc & p[k*BLK+m];
        for (int j = 0; j < i; j++) begin
          term = g[k*BLK+j];
          for (int m = j + 1; m < i; m++) term = term & p[k*BLK+m];
          acc = acc | term;
        end
        c[k*BLK+i] = acc;
      end
    end
    return c;
  endfunction

  logic             s1_valid, s2_valid, s3_valid;
  logic             rdy1, rdy2, rdy3;
  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic             c0_in;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic [NG-1:0]    s1_gp, s1_gg;
  logic             s1_c0;
  logic [WIDTH-1:0] s2_p, s2_g;
  logic [NG:0]      s2_cg;
  logic [WIDTH:0]   c_all;

  // Ready propagates backwards combinationally so a full pipe can advance every cycle.
  assign rdy3          = !s3_valid || bus.out_ready;
  assign rdy2          = !s2_valid || rdy3;
  assign rdy1          = !s1_valid || rdy2;
  assign bus.in_ready  = rdy1;
  assign bus.out_valid = s3_valid;

  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0_in = bus.in_sub | bus.in_cin;
  assign p_in  = bus.in_a ^ b_eff;
  assign g_in  = bus.in_a & b_eff;
  assign c_all = bit_carry(s2_p, s2_g, s2_cg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
      s1_c0    <= 1'b0;
    end else if (rdy1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_p  <= p_in;
        s1_g  <= g_in;
        s1_gp <= group_prop(p_in);
        s1_gg <= group_gen(p_in, g_in);
        s1_c0 <= c0_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_g     <= '0;
      s2_cg    <= '0;
    end else if (rdy2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p  <= s1_p;
        s2_g  <= s1_g;
        s2_cg <= group_carry(s1_gp, s1_gg, s1_c0);
      end
    end
  end

  // Result registers change only when a real beat enters stage 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid     <= 1'b0;
      bus.out_sum  <= '0;
      bus.out_cout <= 1'b0;
      bus.out_ovf  <= 1'b0;
    end else if (rdy3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        bus.out_sum  <= s2_p ^ c_all[WIDTH-1:0];
        bus.out_cout <= c_all[WIDTH];
        bus.out_ovf  <= c_all[WIDTH] ^ c_all[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed corner vectors, stall/reset behaviour and random
// streams on 32/4, 16/8 and 12/2 instances against an arithmetic reference model.
module tb_cla_adder_pipe;
  localparam int NI = 3;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cla_adder_pipe_if #(.WIDTH(32)) bus32 ();
  cla_adder_pipe_if #(.WIDTH(16)) bus16 ();
  cla_adder_pipe_if #(.WIDTH(12)) bus12 ();

  cla_adder_pipe #(.WIDTH(32), .BLK(4)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  cla_adder_pipe #(.WIDTH(16), .BLK(8)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  cla_adder_pipe #(.WIDTH(12), .BLK(2)) u_dut12 (.clk(clk), .rst(rst), .bus(bus12));

  logic        in_valid_v  [NI];
  logic        in_ready_v  [NI];
  logic [31:0] in_a_v      [NI];
  logic [31:0] in_b_v      [NI];
  logic        in_cin_v    [NI];
  logic        in_sub_v    [NI];
  logic        out_valid_v [NI];
  logic        out_ready_v [NI];
  logic [31:0] out_sum_v   [NI];
  logic        out_cout_v  [NI];
  logic        out_ovf_v   [NI];

  assign bus32.in_valid  = in_valid_v[0];
  assign bus32.in_a      = in_a_v[0];
  assign bus32.in_b      = in_b_v[0];
  assign bus32.in_cin    = in_cin_v[0];
  assign bus32.in_sub    = in_sub_v[0];
  assign bus32.out_ready = out_ready_v[0];
  assign in_ready_v[0]   = bus32.in_ready;
  assign out_valid_v[0]  = bus32.out_valid;
  assign out_sum_v[0]    = bus32.out_sum;
  assign out_cout_v[0]   = bus32.out_cout;
  assign out_ovf_v[0]    = bus32.out_ovf;

  assign bus16.in_valid  = in_valid_v[1];
  assign bus16.in_a      = in_a_v[1][15:0];
  assign bus16.in_b      = in_b_v[1][15:0];
  assign bus16.in_cin    = in_cin_v[1];
  assign bus16.in_sub    = in_sub_v[1];
  assign bus16.out_ready = out_ready_v[1];
  assign in_ready_v[1]   = bus16.in_ready;
  assign out_valid_v[1]  = bus16.out_valid;
  assign out_sum_v[1]    = {16'h0, bus16.out_sum};
  assign out_cout_v[1]   = bus16.out_cout;
  assign out_ovf_v[1]    = bus16.out_ovf;

  assign bus12.in_valid  = in_valid_v[2];
  assign bus12.in_a      = in_a_v[2][11:0];
  assign bus12.in_b      = in_b_v[2][11:0];
  assign bus12.in_cin    = in_cin_v[2];
  assign bus12.in_sub    = in_sub_v[2];
  assign bus12.out_ready = out_ready_v[2];
  assign in_ready_v[2]   = bus12.in_ready;
  assign out_valid_v[2]  = bus12.out_valid;
  assign out_sum_v[2]    = {20'h0, bus12.out_sum};
  assign out_cout_v[2]   = bus12.out_cout;
  assign out_ovf_v[2]    = bus12.out_ovf;

  int          wid   [NI];
  int          n_out [NI];
  logic        done  [NI];
  logic [65:0] exp_q [NI][$];
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] width_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Result = {ovf, cout, sum}: plain integer add of A, B (or ~B) and carry-in.
  function automatic logic [65:0] ref_model(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin,
                                            input logic sub);
    longint unsigned mask, aa, bb, full, sum;
    logic            cout, ovf;
    mask = (64'd1 << w) - 64'd1;
    aa   = 64'(a) & mask;
    bb   = 64'(sub ? ~b : b) & mask;
    full = aa + bb + 64'(sub | cin);
    sum  = full & mask;
    cout = full[w];
    ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    return {ovf, cout, sum};
  endfunction

  function automatic logic [31:0] rand_op(input int w);
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return width_mask(w);
      2:       return 32'd1 << (w - 1);
      3:       return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom();
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < NI; i++) begin
        if (out_valid_v[i] && out_ready_v[i]) begin
          n_out[i]++;
          if (exp_q[i].size() == 0)
            check($sformatf("sb%0d_pending", wid[i]), 66'(exp_q[i].size()), 66'(1));
          else
            check($sformatf("sb%0d", wid[i]),
                  {out_ovf_v[i], out_cout_v[i], 32'h0, out_sum_v[i]}, exp_q[i].pop_front());
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that takes the beat.
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub);
    int          n;
    logic [31:0] m;
    m             = width_mask(wid[i]);
    in_a_v[i]     = a & m;
    in_b_v[i]     = b & m;
    in_cin_v[i]   = cin;
    in_sub_v[i]   = sub;
    in_valid_v[i] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready_v[i]) break;
      n++;
      if (n > 200) begin
        check($sformatf("accept_timeout%0d", wid[i]), 66'(n), 66'(0));
        break;
      end
    end
    exp_q[i].push_back(ref_model(wid[i], a & m, b & m, cin, sub));
    @(posedge clk);
    #1;
    in_valid_v[i] = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] es,
                         input logic ec, input logic eo);
    int lat;
    send(0, a, b, cin, sub);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid_v[0]) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, 66'(lat), 66'(3));
    check({tag, "_sum"}, 66'(out_sum_v[0]), 66'(es));
    check({tag, "_cout"}, 66'(out_cout_v[0]), 66'(ec));
    check({tag, "_ovf"}, 66'(out_ovf_v[0]), 66'(eo));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int i, input int beats);
    int base;
    base = n_out[i];
    for (int k = 0; k < beats; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(i, rand_op(wid[i]), rand_op(wid[i]), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    done[i] = 1'b1;
    for (int n = 0; n < 100 && exp_q[i].size() != 0; n++) @(posedge clk);
    #1;
    check($sformatf("rand%0d_left", wid[i]), 66'(exp_q[i].size()), 66'(0));
    check($sformatf("rand%0d_count", wid[i]), 66'(n_out[i] - base), 66'(beats));
  endtask

  task automatic rand_ready(input int i);
    while (!done[i]) begin
      out_ready_v[i] = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    out_ready_v[i] = 1'b1;
  endtask

  initial begin
    int   base;
    logic saw_low;
    int   highs;
    n_cmp = 0;
    n_err = 0;
    wid   = '{32, 16, 12};
    rst   = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid_v[i]  = 1'b0;
      in_a_v[i]      = '0;
      in_b_v[i]      = '0;
      in_cin_v[i]    = 1'b0;
      in_sub_v[i]    = 1'b0;
      out_ready_v[i] = 1'b1;
      done[i]        = 1'b0;
      n_out[i]       = 0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 66'(out_valid_v[0]), 66'(0));
    check("rst_out_sum", 66'(out_sum_v[0]), 66'(0));
    check("rst_out_cout", 66'(out_cout_v[0]), 66'(0));
    check("rst_out_ovf", 66'(out_ovf_v[0]), 66'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 66'(in_ready_v[0]), 66'(1));
    @(posedge clk);
    #1;

    run_vec("add_5_3",      32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    run_vec("add_ones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_vec("add_max_1",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_vec("sub_5_7",      32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_vec("sub_7_5",      32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_vec("sub_min_1",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Ten back-to-back beats with the sink stalled for cycles 4..8.
    base    = n_out[0];
    saw_low = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++)
          send(0, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin : stall_ctl
        logic        stalled;
        logic [65:0] held;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
          out_ready_v[0] = !(cyc >= 4 && cyc <= 8);
          @(negedge clk);
          if (!in_ready_v[0]) begin
            saw_low = 1'b1;
            check("stall_ready_cause", 66'(out_valid_v[0] && !out_ready_v[0]), 66'(1));
          end
          if (out_valid_v[0] && !out_ready_v[0]) begin
            if (stalled)
              check("stall_hold", {out_ovf_v[0], out_cout_v[0], 32'h0, out_sum_v[0]}, held);
            stalled = 1'b1;
            held    = {out_ovf_v[0], out_cout_v[0], 32'h0, out_sum_v[0]};
          end else begin
            stalled = 1'b0;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    check("stall_in_ready_low", 66'(saw_low), 66'(1));
    check("stall_count", 66'(n_out[0] - base), 66'(10));
    check("stall_left", 66'(exp_q[0].size()), 66'(0));

    // Reset with two beats in flight must discard both.
    out_ready_v[0] = 1'b0;
    send(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    send(0, 32'h0BAD_F00D, 32'h0000_0001, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("flush_pre_valid", 66'(out_valid_v[0]), 66'(1));
    rst = 1'b1;
    #1;
    check("flush_out_valid", 66'(out_valid_v[0]), 66'(0));
    check("flush_out_sum", 66'(out_sum_v[0]), 66'(0));
    exp_q[0].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready_v[0] = 1'b1;
    highs = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid_v[0]) highs++;
    end
    check("flush_no_stale", 66'(highs), 66'(0));
    @(posedge clk);
    #1;

    fork
      rand_run(0, 3000);
      rand_run(1, 10000);
      rand_run(2, 10000);
      rand_ready(0);
      rand_ready(1);
      rand_ready(2);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
